// File: rtl/mrr_loopback_pop_arbiter_if.sv
// Signal bundle between the decode chains, the loopback pop arbiter and the
// single pop port of the per-node loopback queue.
interface mrr_loopback_pop_arbiter_if #(
    parameter int NUM_DECODE_PATHWAYS  = 4,
    parameter int CHIP_ID_LEN          = 8,
    parameter int LOOPBACK_MESSAGE_LEN = 64
);
    logic [NUM_DECODE_PATHWAYS-1:0]             chain_req;
    logic [NUM_DECODE_PATHWAYS*CHIP_ID_LEN-1:0] chain_chip_id;
    logic [NUM_DECODE_PATHWAYS-1:0]             chain_ack;
    logic                                       chain_err;
    logic [LOOPBACK_MESSAGE_LEN-1:0]            chain_message;
    logic [NUM_DECODE_PATHWAYS*CHIP_ID_LEN-1:0] q_pop_chip_id;
    logic [NUM_DECODE_PATHWAYS-1:0]             q_pop_request;
    logic [NUM_DECODE_PATHWAYS-1:0]             q_pop_ack;
    logic [LOOPBACK_MESSAGE_LEN-1:0]            q_pop_message;
    logic                                       busy;
    logic                                       timeout_pulse;

    modport master (
        input  chain_req, chain_chip_id, q_pop_ack, q_pop_message,
        output chain_ack, chain_err, chain_message, q_pop_chip_id,
               q_pop_request, busy, timeout_pulse
    );

    modport slave (
        output chain_req, chain_chip_id, q_pop_ack, q_pop_message,
        input  chain_ack, chain_err, chain_message, q_pop_chip_id,
               q_pop_request, busy, timeout_pulse
    );
endinterface

// File: rtl/mrr_loopback_pop_arbiter.sv
// Round-robin arbiter granting one decode chain at a time onto the loopback
// queue pop port, with a bounded wait for the queue's answer.
module mrr_loopback_pop_arbiter #(
    parameter int NUM_DECODE_PATHWAYS  = 4,
    parameter int CHIP_ID_LEN          = 8,
    parameter int LOOPBACK_MESSAGE_LEN = 64,
    parameter int POP_TIMEOUT          = 1024,
    parameter int POP_TIMEOUT_LOG2     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    mrr_loopback_pop_arbiter_if.master io_bus
);
    localparam int N     = NUM_DECODE_PATHWAYS;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [POP_TIMEOUT_LOG2-1:0] TMO_LAST = POP_TIMEOUT_LOG2'(POP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                          r_state;
    logic [PTR_W-1:0]                r_rr_ptr;
    logic [N-1:0]                    r_grant;
    logic [PTR_W-1:0]                r_grant_idx;
    logic [CHIP_ID_LEN-1:0]          r_chip_id;
    logic [POP_TIMEOUT_LOG2-1:0]     r_tmo_cnt;
    logic [LOOPBACK_MESSAGE_LEN-1:0] r_message;
    logic                            r_err;

    state_t                          w_state_next;
    logic [PTR_W-1:0]                w_rr_ptr_next;
    logic [N-1:0]                    w_grant_next;
    logic [PTR_W-1:0]                w_grant_idx_next;
    logic [CHIP_ID_LEN-1:0]          w_chip_id_next;
    logic [POP_TIMEOUT_LOG2-1:0]     w_tmo_cnt_next;
    logic [LOOPBACK_MESSAGE_LEN-1:0] w_message_next;
    logic                            w_err_next;

    logic                            w_found;
    logic [PTR_W-1:0]                w_sel_idx;
    logic [N-1:0]                    w_sel_grant;
    logic [CHIP_ID_LEN-1:0]          w_sel_chip;
    logic                            w_ack_hit;
    logic                            w_tmo_hit;
    logic                            w_req_held;
    logic [PTR_W-1:0]                w_rr_after;

    // Rotating search: first pass covers rr_ptr..N-1, second wraps to 0..rr_ptr-1.
    always_comb begin
        w_found     = 1'b0;
        w_sel_idx   = '0;
        w_sel_grant = '0;
        w_sel_chip  = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && io_bus.chain_req[i] && (i >= int'(r_rr_ptr))) begin
                w_found        = 1'b1;
                w_sel_idx      = PTR_W'(i);
                w_sel_grant[i] = 1'b1;
                w_sel_chip     = io_bus.chain_chip_id[i*CHIP_ID_LEN +: CHIP_ID_LEN];
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && io_bus.chain_req[i] && (i < int'(r_rr_ptr))) begin
                w_found        = 1'b1;
                w_sel_idx      = PTR_W'(i);
                w_sel_grant[i] = 1'b1;
                w_sel_chip     = io_bus.chain_chip_id[i*CHIP_ID_LEN +: CHIP_ID_LEN];
            end
        end
    end

    assign w_ack_hit  = (r_state == S_REQ) && (|(io_bus.q_pop_ack & r_grant));
    assign w_tmo_hit  = (r_state == S_REQ) && !w_ack_hit && (r_tmo_cnt == TMO_LAST);
    assign w_req_held = |(io_bus.chain_req & r_grant);
    assign w_rr_after = (r_grant_idx == PTR_W'(N - 1)) ? '0 : r_grant_idx + 1'b1;

    always_comb begin
        w_state_next     = r_state;
        w_rr_ptr_next    = r_rr_ptr;
        w_grant_next     = r_grant;
        w_grant_idx_next = r_grant_idx;
        w_chip_id_next   = r_chip_id;
        w_tmo_cnt_next   = r_tmo_cnt;
        w_message_next   = r_message;
        w_err_next       = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next     = S_REQ;
                    w_grant_next     = w_sel_grant;
                    w_grant_idx_next = w_sel_idx;
                    w_chip_id_next   = w_sel_chip;
                    w_tmo_cnt_next   = '0;
                end
            end
            S_REQ: begin
                w_tmo_cnt_next = r_tmo_cnt + 1'b1;
                if (w_ack_hit) begin
                    w_message_next = io_bus.q_pop_message;
                    w_err_next     = 1'b0;
                    w_state_next   = S_ACK;
                end else if (w_tmo_hit) begin
                    w_message_next = '0;
                    w_err_next     = 1'b1;
                    w_state_next   = S_ACK;
                end
            end
            S_ACK: begin
                if (!w_req_held) begin
                    w_rr_ptr_next = w_rr_after;
                    w_grant_next  = '0;
                    w_state_next  = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_chip_id   <= '0;
            r_tmo_cnt   <= '0;
            r_message   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_grant     <= w_grant_next;
            r_grant_idx <= w_grant_idx_next;
            r_chip_id   <= w_chip_id_next;
            r_tmo_cnt   <= w_tmo_cnt_next;
            r_message   <= w_message_next;
            r_err       <= w_err_next;
        end
    end

    // Queue-facing outputs come only from registered state so the queue never sees input glitches.
    always_comb begin
        io_bus.q_pop_request = '0;
        io_bus.q_pop_chip_id = '0;
        io_bus.chain_ack     = '0;
        if (r_state == S_REQ) begin
            io_bus.q_pop_request = r_grant;
            for (int i = 0; i < N; i++) begin
                if (r_grant[i]) begin
                    io_bus.q_pop_chip_id[i*CHIP_ID_LEN +: CHIP_ID_LEN] = r_chip_id;
                end
            end
        end
        if (r_state == S_ACK) begin
            io_bus.chain_ack = r_grant;
        end
    end

    assign io_bus.chain_err     = r_err;
    assign io_bus.chain_message = r_message;
    assign io_bus.busy          = (r_state != S_IDLE);
    assign io_bus.timeout_pulse = w_tmo_hit;
endmodule

// File: tb/tb_mrr_loopback_pop_arbiter.sv
// Directed and randomized transactions against a transaction-level round-robin
// model: expected grant, latched chip ID, message/error outcome and timing.
module tb_mrr_loopback_pop_arbiter;
    localparam int N        = 4;
    localparam int CL       = 8;
    localparam int ML       = 64;
    localparam int TMO      = 16;
    localparam int TMO_LOG2 = 4;
    localparam int IDW      = N * CL;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mrr_loopback_pop_arbiter_if #(
        .NUM_DECODE_PATHWAYS (N),
        .CHIP_ID_LEN         (CL),
        .LOOPBACK_MESSAGE_LEN(ML)
    ) bus ();

    mrr_loopback_pop_arbiter #(
        .NUM_DECODE_PATHWAYS (N),
        .CHIP_ID_LEN         (CL),
        .LOOPBACK_MESSAGE_LEN(ML),
        .POP_TIMEOUT         (TMO),
        .POP_TIMEOUT_LOG2    (TMO_LOG2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    int mRrPtr      = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int pickGrant(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [IDW-1:0] placeId(input int g, input logic [CL-1:0] id);
        logic [IDW-1:0] v;
        v = '0;
        v[g*CL +: CL] = id;
        return v;
    endfunction

    // Called in an IDLE cycle with chain_req already driven; returns in the IDLE cycle after ACK.
    task automatic applyStimulus(input string tag, input int ackAfter, input logic [ML-1:0] msg,
                                 input int hold, input bit dropEarly);
        int             g;
        int             c;
        int             lastH;
        logic [CL-1:0]  id;
        logic [N-1:0]   gm;
        bit             acked;
        bit             timedOut;
        bit             expTp;
        g  = pickGrant(bus.chain_req, mRrPtr);
        id = bus.chain_chip_id[g*CL +: CL];
        gm = '0;
        gm[g] = 1'b1;
        tick();
        acked    = 1'b0;
        timedOut = 1'b0;
        c        = 1;
        while (!acked && !timedOut) begin
            bus.chain_chip_id = IDW'($urandom);
            if (dropEarly && c == 1) bus.chain_req[g] = 1'b0;
            if (c == ackAfter) begin
                bus.q_pop_ack     = gm | (N'($urandom) & ~gm);
                bus.q_pop_message = msg;
                acked             = 1'b1;
            end else begin
                bus.q_pop_ack     = (c == 1) ? ~gm : (N'($urandom) & ~gm);
                bus.q_pop_message = {$urandom, $urandom};
            end
            expTp = !acked && (c == TMO);
            settle();
            checkOutput({tag, " q_pop_request"}, bus.q_pop_request, gm);
            checkOutput({tag, " q_pop_chip_id"}, bus.q_pop_chip_id, placeId(g, id));
            checkOutput({tag, " busy_req"}, bus.busy, 1'b1);
            checkOutput({tag, " chain_ack_req"}, bus.chain_ack, '0);
            checkOutput({tag, " timeout_pulse"}, bus.timeout_pulse, expTp);
            if (expTp) timedOut = 1'b1;
            c++;
            tick();
        end
        lastH = dropEarly ? 0 : hold;
        for (int h = 0; h <= lastH; h++) begin
            bus.q_pop_ack     = '1;
            bus.q_pop_message = {$urandom, $urandom};
            bus.chain_chip_id = IDW'($urandom);
            if (h == lastH) bus.chain_req[g] = 1'b0;
            settle();
            checkOutput({tag, " chain_ack"}, bus.chain_ack, gm);
            checkOutput({tag, " chain_err"}, bus.chain_err, timedOut);
            checkOutput({tag, " chain_message"}, bus.chain_message, timedOut ? '0 : msg);
            checkOutput({tag, " q_pop_request_ack"}, bus.q_pop_request, '0);
            checkOutput({tag, " busy_ack"}, bus.busy, 1'b1);
            checkOutput({tag, " timeout_pulse_ack"}, bus.timeout_pulse, 1'b0);
            tick();
        end
        settle();
        checkOutput({tag, " busy_idle"}, bus.busy, 1'b0);
        checkOutput({tag, " chain_ack_idle"}, bus.chain_ack, '0);
        checkOutput({tag, " q_pop_request_idle"}, bus.q_pop_request, '0);
        mRrPtr = (g + 1) % N;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.chain_req     = '0;
        bus.chain_chip_id = '0;
        bus.q_pop_ack     = '0;
        bus.q_pop_message = '0;
        repeat (2) tick();
        checkOutput("reset chain_ack", bus.chain_ack, '0);
        checkOutput("reset chain_err", bus.chain_err, 1'b0);
        checkOutput("reset chain_message", bus.chain_message, '0);
        checkOutput("reset q_pop_request", bus.q_pop_request, '0);
        checkOutput("reset q_pop_chip_id", bus.q_pop_chip_id, '0);
        checkOutput("reset busy", bus.busy, 1'b0);
        checkOutput("reset timeout_pulse", bus.timeout_pulse, 1'b0);
        rst = 1'b0;
        tick();

        bus.chain_req     = 4'b0100;
        bus.chain_chip_id = IDW'($urandom);
        bus.chain_chip_id[2*CL +: CL] = 8'h15;
        settle();
        applyStimulus("single", 12, 64'hDEAD_BEEF_0000_0015, 0, 1'b0);

        // Chains 0 and 3 compete; the pointer left after chain 2 must favour chain 3.
        bus.chain_req = 4'b1001;
        settle();
        applyStimulus("ptr", TMO, {$urandom, $urandom}, 0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            bus.chain_req = '1;
            settle();
            applyStimulus("allreq", int'($urandom_range(1, 8)), {$urandom, $urandom}, 0, 1'b0);
        end
        bus.chain_req = '0;
        repeat (3) begin
            tick();
            checkOutput("norq busy", bus.busy, 1'b0);
            checkOutput("norq q_pop_request", bus.q_pop_request, '0);
        end

        bus.chain_req = 4'b0100;
        settle();
        applyStimulus("timeout", -1, {$urandom, $urandom}, 6, 1'b0);

        bus.chain_req = 4'b0011;
        settle();
        applyStimulus("hold", 5, {$urandom, $urandom}, 10, 1'b0);
        applyStimulus("pending", 3, {$urandom, $urandom}, 0, 1'b1);

        for (int t = 0; t < 20; t++) begin
            int ackAfter;
            bus.chain_req     = bus.chain_req | N'($urandom_range(1, 15));
            bus.chain_chip_id = IDW'($urandom);
            ackAfter = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TMO));
            settle();
            applyStimulus("rand", ackAfter, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0));
        end

        bus.chain_req = 4'b0100;
        settle();
        applyStimulus("prereset", 2, {$urandom, $urandom}, 0, 1'b0);

        // Abandon a transaction three cycles into REQ.
        bus.chain_req = 4'b0010;
        bus.q_pop_ack = '0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("midreset chain_ack", bus.chain_ack, '0);
        checkOutput("midreset chain_err", bus.chain_err, 1'b0);
        checkOutput("midreset chain_message", bus.chain_message, '0);
        checkOutput("midreset q_pop_request", bus.q_pop_request, '0);
        checkOutput("midreset q_pop_chip_id", bus.q_pop_chip_id, '0);
        checkOutput("midreset busy", bus.busy, 1'b0);
        checkOutput("midreset timeout_pulse", bus.timeout_pulse, 1'b0);
        rst           = 1'b0;
        mRrPtr        = 0;
        bus.chain_req = '1;
        settle();
        applyStimulus("postreset", 4, {$urandom, $urandom}, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
